// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder scan sequencer: default widths,
// decoder address space size and the sequencer state encoding.
package decoder_scan_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int DWELL_W_DEF = 4;
  localparam int SCAN_SPACE  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter that times how long each address is held.
// Load has priority over hold; the count parks at zero, where tc is high.
module scan_dwell_timer
  import decoder_scan_pkg::*;
#(
  parameter int W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, otherwise decrement unless frozen or already at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Address generator feeding decoder_6x64: on start it walks a run of
// consecutive addresses, holding each for dwell+1 cycles, with stall,
// abort and a one-cycle done pulse. All outputs are registered.
// Optional continuous scanning is enabled by defining SCAN_LOOP_EN,
// which adds the loop input.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base,
  input  logic [ADDR_W:0]    count,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  input  logic               abort,
`ifdef SCAN_LOOP_EN
  input  logic               loop,
`endif
  output logic               dec_en,
  output logic [ADDR_W-1:0]  dec_addr,
  output logic               busy,
  output logic               done
);

  // Largest meaningful run length: the whole address space.
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  scan_state_t        state_q, state_d;
  logic               dec_en_q, dec_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ADDR_W:0]    rem_q, rem_d;     // addresses still to visit after the current one
  logic [DWELL_W-1:0] dwell_q, dwell_d;
`ifdef SCAN_LOOP_EN
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               loop_q, loop_d;
`endif

  logic [ADDR_W:0]    count_sat;
  logic               timer_load;
  logic               timer_hold;
  logic [DWELL_W-1:0] timer_val;
  logic               timer_tc;

  assign count_sat = (count > MAX_CNT) ? MAX_CNT : count;

  // The run start loads the fresh dwell input; later reloads use the latched copy.
  assign timer_val  = (state_q == IDLE) ? dwell : dwell_q;
  // Dwell counting only advances in RUN while neither stalled nor aborting.
  assign timer_hold = (state_q != RUN) | hold | abort;

  scan_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .hold     (timer_hold),
    .tc       (timer_tc)
  );

  // Next-state and next-output logic of the scan FSM.
  always_comb begin
    state_d    = state_q;
    dec_en_d   = dec_en_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rem_d      = rem_q;
    dwell_d    = dwell_q;
    timer_load = 1'b0;
`ifdef SCAN_LOOP_EN
    base_d     = base_q;
    cnt_d      = cnt_q;
    loop_d     = loop_q;
`endif
    case (state_q)
      IDLE: begin
        dec_en_d = 1'b0;
        busy_d   = 1'b0;
        if (start) begin
          dwell_d = dwell;
`ifdef SCAN_LOOP_EN
          base_d  = base;
          cnt_d   = count_sat;
          loop_d  = loop;
`endif
          if (count_sat == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = RUN;
            dec_en_d   = 1'b1;
            busy_d     = 1'b1;
            addr_d     = base;
            rem_d      = count_sat - 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          dec_en_d = 1'b0;
          busy_d   = 1'b0;
        end else if (!hold && timer_tc) begin
          if (rem_q == '0) begin
`ifdef SCAN_LOOP_EN
            if (loop_q) begin
              addr_d     = base_q;
              rem_d      = cnt_q - 1'b1;
              timer_load = 1'b1;
            end else begin
              state_d  = DONE;
              dec_en_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end
`else
            state_d  = DONE;
            dec_en_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`endif
          end else begin
            addr_d     = addr_q + 1'b1;
            rem_d      = rem_q - 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        dec_en_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        dec_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dec_en_q <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= '0;
      dwell_q  <= '0;
`ifdef SCAN_LOOP_EN
      base_q   <= '0;
      cnt_q    <= '0;
      loop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dec_en_q <= dec_en_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
      dwell_q  <= dwell_d;
`ifdef SCAN_LOOP_EN
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      loop_q   <= loop_d;
`endif
    end
  end

  assign dec_en   = dec_en_q;
  assign dec_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer. Outputs are sampled 1 ns after
// each rising edge; inputs are changed at the same point.
module tb_decoder_scan_sequencer;

  localparam int ADDR_W  = 6;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W:0]    count;
  logic [DWELL_W-1:0] dwell;
  logic               hold;
  logic               abort;
`ifdef SCAN_LOOP_EN
  logic               loop;
`endif
  logic               dec_en;
  logic [ADDR_W-1:0]  dec_addr;
  logic               busy;
  logic               done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .count    (count),
    .dwell    (dwell),
    .hold     (hold),
    .abort    (abort),
`ifdef SCAN_LOOP_EN
    .loop     (loop),
`endif
    .dec_en   (dec_en),
    .dec_addr (dec_addr),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs expected while not scanning.
  task automatic chk_off(input string tag, input logic exp_done);
    chk({tag, ".dec_en"}, 32'(dec_en), 32'd0);
    chk({tag, ".busy"},   32'(busy),   32'd0);
    chk({tag, ".done"},   32'(done),   32'(exp_done));
  endtask

  task automatic launch(input int b, input int c, input int d);
    base  = 6'(b);
    count = 7'(c);
    dwell = 4'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expect n addresses from b (mod 64), each held dw+1 cycles, then one done.
  task automatic run_check(input string tag, input int b, input int n, input int dw);
    for (int a = 0; a < n; a++) begin
      for (int k = 0; k <= dw; k++) begin
        chk({tag, ".dec_en"},   32'(dec_en),   32'd1);
        chk({tag, ".dec_addr"}, 32'(dec_addr), 32'((b + a) % 64));
        chk({tag, ".busy"},     32'(busy),     32'd1);
        chk({tag, ".done"},     32'(done),     32'd0);
        tick();
      end
    end
    chk_off({tag, ".end"}, 1'b1);
  endtask

  int   stall_addr [7] = '{5, 5, 5, 5, 5, 6, 6};
  logic stall_hold [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; start = 1'b0; base = 6'd33; count = 7'd5; dwell = 4'd0;
    hold = 1'b0; abort = 1'b0;
`ifdef SCAN_LOOP_EN
    loop = 1'b0;
`endif
    tick();
    tick();
    // Reset state
    chk_off("reset", 1'b0);
    chk("reset.dec_addr", 32'(dec_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_off("idle", 1'b0);

    // Basic run 10..13, then start during DONE must not be queued
    launch(10, 4, 0);
    run_check("basic", 10, 4, 0);
    base = 6'd20; count = 7'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk_off("start_in_done", 1'b0);
    chk("hold_addr_idle", 32'(dec_addr), 32'd13);
    tick();
    chk_off("no_queue", 1'b0);

    // Wrap with dwell: 62,63,0,1 each held 3 cycles
    launch(62, 4, 2);
    run_check("wrap", 62, 4, 2);
    tick();
    chk_off("wrap.after", 1'b0);

    // Stall: hold on address 5's second cycle for 3 cycles
    launch(5, 2, 1);
    for (int i = 0; i < 7; i++) begin
      chk("stall.dec_en",   32'(dec_en),   32'd1);
      chk("stall.dec_addr", 32'(dec_addr), 32'(stall_addr[i]));
      chk("stall.done",     32'(done),     32'd0);
      hold = stall_hold[i];
      tick();
    end
    chk_off("stall.end", 1'b1);
    tick();

    // Abort on address 3; mid-run start ignored; abort beats hold
    launch(0, 10, 0);
    chk("abort.a0", 32'(dec_addr), 32'd0);
    tick();
    chk("abort.a1", 32'(dec_addr), 32'd1);
    base = 6'd40; count = 7'd2; dwell = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("midstart.a2", 32'(dec_addr), 32'd2);
    chk("midstart.busy", 32'(busy), 32'd1);
    tick();
    chk("abort.a3", 32'(dec_addr), 32'd3);
    abort = 1'b1; hold = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0;
    chk_off("abort", 1'b0);
    chk("abort.addr_held", 32'(dec_addr), 32'd3);
    tick();
    chk_off("abort.no_done", 1'b0);

    // count=0: immediate done, dec_en never rises
    launch(9, 0, 3);
    chk_off("count0", 1'b1);
    tick();
    chk_off("count0.after", 1'b0);
    // Start accepted in the IDLE cycle right after DONE; count=100 saturates to 64
    launch(0, 100, 0);
    run_check("count100", 0, 64, 0);
    tick();

    // Reset mid-run
    launch(20, 5, 3);
    tick();
    tick();
    chk("rstrun.pre_en", 32'(dec_en), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_off("rstrun", 1'b0);
    chk("rstrun.dec_addr", 32'(dec_addr), 32'd0);
    tick();
    chk_off("rstrun.idle", 1'b0);

`ifdef SCAN_LOOP_EN
    // Continuous scan 7,8,9,7,8,9,... until abort, never done
    loop = 1'b1;
    launch(7, 3, 0);
    loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("loop.dec_en",   32'(dec_en),   32'd1);
      chk("loop.dec_addr", 32'(dec_addr), 32'(7 + (i % 3)));
      chk("loop.done",     32'(done),     32'd0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_off("loop.abort", 1'b0);
    tick();
    chk_off("loop.after", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
